bpu_update_queue: RTL and testbench
===================================

# bpu_update_queue

Branch-update generator feeding the BPU training port. It captures the per-branch prediction record emitted at predecode into an in-order queue. It pairs each record with the in-order resolution reported by the execution unit, then drives one registered update beat (valid, new-branch, alias-error, outcome, target, BTB/PHT indices) into the BPU `i_iq_bpu_*` inputs. A pipeline flush empties the queue.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, ≥2.
- `PC_W`, 32: PC width (`CORE_PC_WIDTH`).
- `BTB_IDX_W`, 4: BTB index width (`BTB_IDX_WIDTH`).
- `PHT_IDX_W`, 8: PHT index width (`PHT_IDX_WIDTH`).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_flush`  in  1  OR of trap/mispredict/load-store flush; clears queue.
- `i_pd_vld`  in  1  predecode offers one branch record.
- `o_pd_rdy`  out  1  queue accepts record (`~full`).
- `i_pd_btb_match`  in  1  BTB hit at fetch.
- `i_pd_pred_taken`  in  1  predicted taken.
- `i_pd_is_cond`  in  1  decoded type: 1 conditional, 0 unconditional.
- `i_pd_btb_type`  in  1  type stored in BTB entry.
- `i_pd_br_pc`  in  PC_W  branch instruction PC.
- `i_pd_btb_idx`  in  BTB_IDX_W  BTB entry index.
- `i_pd_pht_idx`  in  PHT_IDX_W  PHT index used.
- `i_pd_pht_entry`  in  2  PHT counter value read.
- `i_exu_res_vld`  in  1  oldest branch resolved (program order).
- `i_exu_res_taken`  in  1  actual direction.
- `i_exu_res_taddr`  in  PC_W  actual target.
- `o_iq_bpu_vld`, `o_iq_bpu_taken`, `o_iq_bpu_new_br`, `o_iq_bpu_btb_type`, `o_iq_bpu_alias_err`, `o_iq_bpu_tsucc`  out  1 each  update beat fields.
- `o_iq_bpu_btb_addr`, `o_iq_bpu_btb_taddr`  out  PC_W  branch PC, resolved target.
- `o_iq_bpu_btb_idx`  out  BTB_IDX_W;  `o_iq_bpu_pht_idx`  out  PHT_IDX_W;  `o_iq_bpu_pht_entry`  out  2.
- `o_upq_empty`, `o_upq_full`  out  1  occupancy status.
- `o_upq_underflow`  out  1  one-cycle pulse: resolve with empty queue.

## Operation
- Storage: circular buffer, `DEPTH` entries. Read/write pointers are `log2(DEPTH)` bits and wrap naturally. Count is `log2(DEPTH)+1` bits.
- Push: `i_pd_vld & o_pd_rdy & ~i_flush` writes at the write pointer, then increments it.
- Pop: `i_exu_res_vld & ~empty & ~i_flush` reads the head, then increments the read pointer.
- Push and pop in the same cycle: count unchanged.
- `o_pd_rdy = ~full`. It uses registered count only and does not depend on a same-cycle pop.
- Update generation on a pop, from head entry H and resolution R:
  - `alias_err = H.btb_match & (H.btb_type != H.is_cond)`.
  - `new_br = ~H.btb_match & R.taken`.
  - `vld = H.btb_match | R.taken`. A not-taken branch with no BTB hit produces no beat.
  - `taken = H.pred_taken`; `tsucc = R.taken`.
  - `btb_type = H.btb_match ? H.btb_type : H.is_cond`.
  - `btb_taddr = R.taddr`; remaining fields copy from H.
- Underflow: `i_exu_res_vld & empty & ~i_flush` pulses `o_upq_underflow`. No beat is produced and no state changes.
- Flush: pointers and count go to 0 and `o_iq_bpu_vld` is 0 next cycle. Any push, pop or underflow in the same cycle is discarded.

## Timing
- Reset: pointers, count, all `o_iq_bpu_*`, and `o_upq_underflow` are 0. `o_upq_empty` is 1, `o_upq_full` is 0, `o_pd_rdy` is 1.
- Latency: a pop in cycle N gives a registered update beat in cycle N+1. `o_iq_bpu_vld` stays high exactly one cycle per beat. Data registers hold their value when vld is 0.
- No bypass: a push and a resolve in the same cycle on an empty queue gives an underflow. The pushed record remains queued.
- Status flags derive from registered count and change the cycle after a push or pop.
- Throughput: one push and one pop per cycle sustained. The BPU side has no backpressure.

## Test plan
- Reset, then push one record (match=0, is_cond=1, pc=0x100, btb_idx=3, pht_idx=0x2A, entry=2'b01). Resolve taken with taddr=0x180. Required: next cycle vld=1, new_br=1, tsucc=1, btb_addr=0x100, btb_taddr=0x180, btb_type=1, alias_err=0.
- Push match=1, btb_type=1, is_cond=0, then resolve taken. Required: vld=1, alias_err=1, new_br=0.
- Push 8 records (DEPTH=8). Required: full=1 and rdy=0. A 9th push is ignored. Eight resolves return the records in order with pointer wrap. Afterwards empty=1.
- Queue full: drive push and pop in the same cycle. Required: the push is rejected because rdy=0 and count becomes 7. At count 4, push and pop together keep count at 4.
- With 5 entries queued, assert `i_flush` together with `i_exu_res_vld`. Required: no beat, empty=1 next cycle, rdy=1.
- Resolve on empty: `o_upq_underflow` pulses 1 cycle and vld=0. Resolve without a BTB match and not taken: vld=0, entry popped.

Source files
------------

// File: rtl/bpu_update_queue_if.sv
// Signal bundle between predecode/EXU/BPU and the branch-update queue.
// Predecode handshake: a record transfers on a rising clk edge when i_pd_vld & o_pd_rdy; o_pd_rdy never depends on i_pd_vld, and the EXU and BPU sides have no backpressure.
interface bpu_update_queue_if #(
    parameter int PC_W      = 32,
    parameter int BTB_IDX_W = 4,
    parameter int PHT_IDX_W = 8
);
    logic                 i_flush;
    logic                 i_pd_vld;
    logic                 o_pd_rdy;
    logic                 i_pd_btb_match;
    logic                 i_pd_pred_taken;
    logic                 i_pd_is_cond;
    logic                 i_pd_btb_type;
    logic [PC_W-1:0]      i_pd_br_pc;
    logic [BTB_IDX_W-1:0] i_pd_btb_idx;
    logic [PHT_IDX_W-1:0] i_pd_pht_idx;
    logic [1:0]           i_pd_pht_entry;
    logic                 i_exu_res_vld;
    logic                 i_exu_res_taken;
    logic [PC_W-1:0]      i_exu_res_taddr;
    logic                 o_iq_bpu_vld;
    logic                 o_iq_bpu_taken;
    logic                 o_iq_bpu_new_br;
    logic                 o_iq_bpu_btb_type;
    logic                 o_iq_bpu_alias_err;
    logic                 o_iq_bpu_tsucc;
    logic [PC_W-1:0]      o_iq_bpu_btb_addr;
    logic [PC_W-1:0]      o_iq_bpu_btb_taddr;
    logic [BTB_IDX_W-1:0] o_iq_bpu_btb_idx;
    logic [PHT_IDX_W-1:0] o_iq_bpu_pht_idx;
    logic [1:0]           o_iq_bpu_pht_entry;
    logic                 o_upq_empty;
    logic                 o_upq_full;
    logic                 o_upq_underflow;

    modport master (
        output i_flush, i_pd_vld, i_pd_btb_match, i_pd_pred_taken, i_pd_is_cond,
               i_pd_btb_type, i_pd_br_pc, i_pd_btb_idx, i_pd_pht_idx, i_pd_pht_entry,
               i_exu_res_vld, i_exu_res_taken, i_exu_res_taddr,
        input  o_pd_rdy, o_iq_bpu_vld, o_iq_bpu_taken, o_iq_bpu_new_br,
               o_iq_bpu_btb_type, o_iq_bpu_alias_err, o_iq_bpu_tsucc,
               o_iq_bpu_btb_addr, o_iq_bpu_btb_taddr, o_iq_bpu_btb_idx,
               o_iq_bpu_pht_idx, o_iq_bpu_pht_entry, o_upq_empty, o_upq_full,
               o_upq_underflow
    );

    modport slave (
        input  i_flush, i_pd_vld, i_pd_btb_match, i_pd_pred_taken, i_pd_is_cond,
               i_pd_btb_type, i_pd_br_pc, i_pd_btb_idx, i_pd_pht_idx, i_pd_pht_entry,
               i_exu_res_vld, i_exu_res_taken, i_exu_res_taddr,
        output o_pd_rdy, o_iq_bpu_vld, o_iq_bpu_taken, o_iq_bpu_new_br,
               o_iq_bpu_btb_type, o_iq_bpu_alias_err, o_iq_bpu_tsucc,
               o_iq_bpu_btb_addr, o_iq_bpu_btb_taddr, o_iq_bpu_btb_idx,
               o_iq_bpu_pht_idx, o_iq_bpu_pht_entry, o_upq_empty, o_upq_full,
               o_upq_underflow
    );
endinterface

// File: rtl/bpu_update_queue.sv
// In-order queue of predecode branch records; each EXU resolution pops the head
// and emits one registered BPU training beat.
module bpu_update_queue #(
    parameter int DEPTH     = 8,
    parameter int PC_W      = 32,
    parameter int BTB_IDX_W = 4,
    parameter int PHT_IDX_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    bpu_update_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic                 btb_match;
        logic                 pred_taken;
        logic                 is_cond;
        logic                 btb_type;
        logic [PC_W-1:0]      br_pc;
        logic [BTB_IDX_W-1:0] btb_idx;
        logic [PHT_IDX_W-1:0] pht_idx;
        logic [1:0]           pht_entry;
    } entry_t;

    entry_t mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic                 vld_q, taken_q, new_br_q, btb_type_q, alias_err_q, tsucc_q;
    logic [PC_W-1:0]      btb_addr_q, btb_taddr_q;
    logic [BTB_IDX_W-1:0] btb_idx_q;
    logic [PHT_IDX_W-1:0] pht_idx_q;
    logic [1:0]           pht_entry_q;
    logic                 underflow_q;

    logic   empty, full, push, pop, underflow, beat_vld;
    entry_t wr_entry, head;

    // Status comes from the registered count only, so ready never sees a same-cycle pop.
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    assign push      = bus.i_pd_vld & ~full & ~bus.i_flush;
    assign pop       = bus.i_exu_res_vld & ~empty & ~bus.i_flush;
    assign underflow = bus.i_exu_res_vld & empty & ~bus.i_flush;

    assign head     = mem_q[rd_ptr_q];
    assign beat_vld = pop & (head.btb_match | bus.i_exu_res_taken);

    assign wr_entry = '{
        btb_match:  bus.i_pd_btb_match,
        pred_taken: bus.i_pd_pred_taken,
        is_cond:    bus.i_pd_is_cond,
        btb_type:   bus.i_pd_btb_type,
        br_pc:      bus.i_pd_br_pc,
        btb_idx:    bus.i_pd_btb_idx,
        pht_idx:    bus.i_pd_pht_idx,
        pht_entry:  bus.i_pd_pht_entry
    };

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Beat payload only moves when a beat is issued; otherwise the last beat is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= 1'b0;
            underflow_q <= 1'b0;
            taken_q     <= 1'b0;
            new_br_q    <= 1'b0;
            btb_type_q  <= 1'b0;
            alias_err_q <= 1'b0;
            tsucc_q     <= 1'b0;
            btb_addr_q  <= '0;
            btb_taddr_q <= '0;
            btb_idx_q   <= '0;
            pht_idx_q   <= '0;
            pht_entry_q <= '0;
        end else begin
            vld_q       <= beat_vld;
            underflow_q <= underflow;
            if (beat_vld) begin
                taken_q     <= head.pred_taken;
                new_br_q    <= ~head.btb_match & bus.i_exu_res_taken;
                btb_type_q  <= head.btb_match ? head.btb_type : head.is_cond;
                alias_err_q <= head.btb_match & (head.btb_type != head.is_cond);
                tsucc_q     <= bus.i_exu_res_taken;
                btb_addr_q  <= head.br_pc;
                btb_taddr_q <= bus.i_exu_res_taddr;
                btb_idx_q   <= head.btb_idx;
                pht_idx_q   <= head.pht_idx;
                pht_entry_q <= head.pht_entry;
            end
        end
    end

    assign bus.o_pd_rdy           = ~full;
    assign bus.o_upq_empty        = empty;
    assign bus.o_upq_full         = full;
    assign bus.o_upq_underflow    = underflow_q;
    assign bus.o_iq_bpu_vld       = vld_q;
    assign bus.o_iq_bpu_taken     = taken_q;
    assign bus.o_iq_bpu_new_br    = new_br_q;
    assign bus.o_iq_bpu_btb_type  = btb_type_q;
    assign bus.o_iq_bpu_alias_err = alias_err_q;
    assign bus.o_iq_bpu_tsucc     = tsucc_q;
    assign bus.o_iq_bpu_btb_addr  = btb_addr_q;
    assign bus.o_iq_bpu_btb_taddr = btb_taddr_q;
    assign bus.o_iq_bpu_btb_idx   = btb_idx_q;
    assign bus.o_iq_bpu_pht_idx   = pht_idx_q;
    assign bus.o_iq_bpu_pht_entry = pht_entry_q;
endmodule

// File: tb/tb_bpu_update_queue.sv
// Randomised bench for bpu_update_queue: a queue-of-records model predicts every
// output each cycle, plus directed scenarios with literal expectations.
module tb_bpu_update_queue;
    localparam int DEPTH     = 8;
    localparam int PC_W      = 32;
    localparam int BTB_IDX_W = 4;
    localparam int PHT_IDX_W = 8;

    typedef struct packed {
        logic                 btb_match;
        logic                 pred_taken;
        logic                 is_cond;
        logic                 btb_type;
        logic [PC_W-1:0]      br_pc;
        logic [BTB_IDX_W-1:0] btb_idx;
        logic [PHT_IDX_W-1:0] pht_idx;
        logic [1:0]           pht_entry;
    } rec_t;
    localparam int REC_W = $bits(rec_t);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bpu_update_queue_if #(.PC_W(PC_W), .BTB_IDX_W(BTB_IDX_W), .PHT_IDX_W(PHT_IDX_W)) bus();

    bpu_update_queue #(
        .DEPTH(DEPTH), .PC_W(PC_W), .BTB_IDX_W(BTB_IDX_W), .PHT_IDX_W(PHT_IDX_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Model state: pending records in program order plus the last beat issued.
    logic [REC_W-1:0]     exp_q[$];
    logic                 exp_vld = 0, exp_taken = 0, exp_new_br = 0, exp_type = 0;
    logic                 exp_alias = 0, exp_tsucc = 0, exp_uf = 0;
    logic [PC_W-1:0]      exp_addr = '0, exp_taddr = '0;
    logic [BTB_IDX_W-1:0] exp_bidx = '0;
    logic [PHT_IDX_W-1:0] exp_pidx = '0;
    logic [1:0]           exp_pent = '0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.i_flush         = 0;
        bus.i_pd_vld        = 0;
        bus.i_pd_btb_match  = 0;
        bus.i_pd_pred_taken = 0;
        bus.i_pd_is_cond    = 0;
        bus.i_pd_btb_type   = 0;
        bus.i_pd_br_pc      = '0;
        bus.i_pd_btb_idx    = '0;
        bus.i_pd_pht_idx    = '0;
        bus.i_pd_pht_entry  = '0;
        bus.i_exu_res_vld   = 0;
        bus.i_exu_res_taken = 0;
        bus.i_exu_res_taddr = '0;
    endtask

    task automatic drive_pd(input rec_t r);
        bus.i_pd_vld        = 1;
        bus.i_pd_btb_match  = r.btb_match;
        bus.i_pd_pred_taken = r.pred_taken;
        bus.i_pd_is_cond    = r.is_cond;
        bus.i_pd_btb_type   = r.btb_type;
        bus.i_pd_br_pc      = r.br_pc;
        bus.i_pd_btb_idx    = r.btb_idx;
        bus.i_pd_pht_idx    = r.pht_idx;
        bus.i_pd_pht_entry  = r.pht_entry;
    endtask

    task automatic drive_res(input logic taken, input logic [PC_W-1:0] taddr);
        bus.i_exu_res_vld   = 1;
        bus.i_exu_res_taken = taken;
        bus.i_exu_res_taddr = taddr;
    endtask

    function automatic rec_t rand_rec();
        rec_t r;
        r.btb_match  = 1'($urandom_range(0, 1));
        r.pred_taken = 1'($urandom_range(0, 1));
        r.is_cond    = 1'($urandom_range(0, 1));
        r.btb_type   = 1'($urandom_range(0, 1));
        r.br_pc      = $urandom;
        r.btb_idx    = BTB_IDX_W'($urandom);
        r.pht_idx    = PHT_IDX_W'($urandom);
        r.pht_entry  = 2'($urandom);
        return r;
    endfunction

    // One clock: decide the model's push/pop from the rules, apply them at the edge.
    task automatic step();
        bit   empty_b, full_b, do_push, do_pop, do_uf, flush, taken;
        logic [PC_W-1:0] taddr;
        rec_t r, h;
        r.btb_match  = bus.i_pd_btb_match;
        r.pred_taken = bus.i_pd_pred_taken;
        r.is_cond    = bus.i_pd_is_cond;
        r.btb_type   = bus.i_pd_btb_type;
        r.br_pc      = bus.i_pd_br_pc;
        r.btb_idx    = bus.i_pd_btb_idx;
        r.pht_idx    = bus.i_pd_pht_idx;
        r.pht_entry  = bus.i_pd_pht_entry;
        flush   = bus.i_flush;
        taken   = bus.i_exu_res_taken;
        taddr   = bus.i_exu_res_taddr;
        empty_b = (exp_q.size() == 0);
        full_b  = (exp_q.size() == DEPTH);
        do_push = bus.i_pd_vld && !full_b && !flush;
        do_pop  = bus.i_exu_res_vld && !empty_b && !flush;
        do_uf   = bus.i_exu_res_vld && empty_b && !flush;
        @(posedge clk);
        exp_uf  = do_uf;
        exp_vld = 0;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (do_pop) begin
                h = exp_q.pop_front();
                if (h.btb_match || taken) begin
                    exp_vld    = 1;
                    exp_taken  = h.pred_taken;
                    exp_new_br = !h.btb_match && taken;
                    exp_alias  = h.btb_match && (h.btb_type != h.is_cond);
                    exp_type   = h.btb_match ? h.btb_type : h.is_cond;
                    exp_tsucc  = taken;
                    exp_addr   = h.br_pc;
                    exp_taddr  = taddr;
                    exp_bidx   = h.btb_idx;
                    exp_pidx   = h.pht_idx;
                    exp_pent   = h.pht_entry;
                end
            end
            if (do_push) exp_q.push_back(r);
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("vld",       bus.o_iq_bpu_vld,       exp_vld);
            chk("taken",     bus.o_iq_bpu_taken,     exp_taken);
            chk("new_br",    bus.o_iq_bpu_new_br,    exp_new_br);
            chk("btb_type",  bus.o_iq_bpu_btb_type,  exp_type);
            chk("alias_err", bus.o_iq_bpu_alias_err, exp_alias);
            chk("tsucc",     bus.o_iq_bpu_tsucc,     exp_tsucc);
            chk("btb_addr",  bus.o_iq_bpu_btb_addr,  exp_addr);
            chk("btb_taddr", bus.o_iq_bpu_btb_taddr, exp_taddr);
            chk("btb_idx",   bus.o_iq_bpu_btb_idx,   exp_bidx);
            chk("pht_idx",   bus.o_iq_bpu_pht_idx,   exp_pidx);
            chk("pht_entry", bus.o_iq_bpu_pht_entry, exp_pent);
            chk("underflow", bus.o_upq_underflow,    exp_uf);
            chk("empty",     bus.o_upq_empty,        exp_q.size() == 0);
            chk("full",      bus.o_upq_full,         exp_q.size() == DEPTH);
            chk("pd_rdy",    bus.o_pd_rdy,           exp_q.size() != DEPTH);
        end
    end

    initial begin
        rec_t r;
        idle();
        repeat (3) @(posedge clk);
        chk("rst_empty", bus.o_upq_empty, 1);
        chk("rst_full", bus.o_upq_full, 0);
        chk("rst_rdy", bus.o_pd_rdy, 1);
        chk("rst_vld", bus.o_iq_bpu_vld, 0);
        chk("rst_uf", bus.o_upq_underflow, 0);
        chk("rst_addr", bus.o_iq_bpu_btb_addr, 0);
        @(negedge clk);
        rst_n  = 1;
        chk_en = 1;

        // New taken branch without BTB hit.
        r = '{btb_match: 0, pred_taken: 0, is_cond: 1, btb_type: 0, br_pc: 32'h100,
              btb_idx: 4'd3, pht_idx: 8'h2A, pht_entry: 2'b01};
        drive_pd(r);
        step();
        idle();
        drive_res(1, 32'h180);
        step();
        idle();
        chk("t1_vld", bus.o_iq_bpu_vld, 1);
        chk("t1_new_br", bus.o_iq_bpu_new_br, 1);
        chk("t1_tsucc", bus.o_iq_bpu_tsucc, 1);
        chk("t1_addr", bus.o_iq_bpu_btb_addr, 32'h100);
        chk("t1_taddr", bus.o_iq_bpu_btb_taddr, 32'h180);
        chk("t1_type", bus.o_iq_bpu_btb_type, 1);
        chk("t1_alias", bus.o_iq_bpu_alias_err, 0);
        chk("t1_idx", bus.o_iq_bpu_btb_idx, 3);
        chk("t1_pht", bus.o_iq_bpu_pht_idx, 8'h2A);
        step();
        chk("t1_vld_drop", bus.o_iq_bpu_vld, 0);
        chk("t1_hold", bus.o_iq_bpu_btb_addr, 32'h100);

        // BTB hit whose stored type disagrees with decode.
        r = '{btb_match: 1, pred_taken: 1, is_cond: 0, btb_type: 1, br_pc: 32'h240,
              btb_idx: 4'd9, pht_idx: 8'h11, pht_entry: 2'b11};
        drive_pd(r);
        step();
        idle();
        drive_res(1, 32'h300);
        step();
        idle();
        chk("t2_vld", bus.o_iq_bpu_vld, 1);
        chk("t2_alias", bus.o_iq_bpu_alias_err, 1);
        chk("t2_new_br", bus.o_iq_bpu_new_br, 0);
        chk("t2_type", bus.o_iq_bpu_btb_type, 1);

        // Fill to DEPTH with pointer wrap, reject a ninth push, drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            drive_pd(rand_rec());
            step();
        end
        idle();
        chk("fill_full", bus.o_upq_full, 1);
        chk("fill_rdy", bus.o_pd_rdy, 0);
        drive_pd(rand_rec());
        step();
        idle();
        chk("ninth_full", bus.o_upq_full, 1);
        for (int i = 0; i < DEPTH; i++) begin
            drive_res(1'($urandom_range(0, 1)), $urandom);
            step();
        end
        idle();
        chk("drain_empty", bus.o_upq_empty, 1);

        // Push and pop together while full, then at count 4.
        for (int i = 0; i < DEPTH; i++) begin
            drive_pd(rand_rec());
            step();
        end
        drive_pd(rand_rec());
        drive_res(1, $urandom);
        step();
        idle();
        chk("fullpp_full", bus.o_upq_full, 0);
        chk("fullpp_rdy", bus.o_pd_rdy, 1);
        for (int i = 0; i < 3; i++) begin
            drive_res(1'($urandom_range(0, 1)), $urandom);
            step();
        end
        idle();
        drive_pd(rand_rec());
        drive_res(1, $urandom);
        step();
        idle();
        chk("cnt4_empty", bus.o_upq_empty, 0);
        chk("cnt4_full", bus.o_upq_full, 0);

        // Flush with five queued, colliding with a resolve and a push.
        drive_pd(rand_rec());
        step();
        idle();
        bus.i_flush = 1;
        drive_pd(rand_rec());
        drive_res(1, 32'hDEAD);
        step();
        idle();
        chk("flush_vld", bus.o_iq_bpu_vld, 0);
        chk("flush_empty", bus.o_upq_empty, 1);
        chk("flush_rdy", bus.o_pd_rdy, 1);
        chk("flush_uf", bus.o_upq_underflow, 0);

        // Underflow, then push+resolve on empty, then a silent pop.
        drive_res(1, 32'h44);
        step();
        idle();
        chk("uf_pulse", bus.o_upq_underflow, 1);
        chk("uf_vld", bus.o_iq_bpu_vld, 0);
        step();
        chk("uf_drop", bus.o_upq_underflow, 0);
        r = '{btb_match: 0, pred_taken: 0, is_cond: 1, btb_type: 0, br_pc: 32'h500,
              btb_idx: 4'd1, pht_idx: 8'h05, pht_entry: 2'b10};
        drive_pd(r);
        drive_res(0, 32'h0);
        step();
        idle();
        chk("nobypass_uf", bus.o_upq_underflow, 1);
        chk("nobypass_empty", bus.o_upq_empty, 0);
        drive_res(0, 32'h504);
        step();
        idle();
        chk("silent_vld", bus.o_iq_bpu_vld, 0);
        chk("silent_empty", bus.o_upq_empty, 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            idle();
            if ($urandom_range(0, 99) < 60) drive_pd(rand_rec());
            if ($urandom_range(0, 99) < 55) drive_res(1'($urandom_range(0, 1)), $urandom);
            bus.i_flush = ($urandom_range(0, 99) < 3);
            step();
        end
        idle();
        repeat (3) step();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
